// File: rtl/shift_receiver_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding.
package shift_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/shift_in_register.sv
// Serial-to-parallel shift register with bit counter; last_bit marks the final data bit slot.
module shift_in_register #(
  parameter int DATA_BITS = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 clear,
  input  logic                 serial_bit,
  output logic [DATA_BITS-1:0] word,
  output logic                 last_bit
);

  localparam int unsigned CW = $clog2(DATA_BITS);

  logic [CW-1:0] count;

  assign last_bit = (count == CW'(DATA_BITS - 1));

  // clear only rewinds the counter; every data bit overwrites the word anyway
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      word  <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (shift_en) begin
      count <= count + CW'(1);
      if (LSB_FIRST != 0) word <= {serial_bit, word[DATA_BITS-1:1]};
      else                word <= {word[DATA_BITS-2:0], serial_bit};
    end
  end

endmodule

// File: rtl/shift_receiver.sv
// Strobed serial frame receiver: start/data/stop FSM with a one-deep Valid/Ready output register.
module shift_receiver
  import shift_receiver_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 SerialIn,
  input  logic                 BitStrobe,
  input  logic                 Ready,
  input  logic                 ClearFlags,
  output logic [DATA_BITS-1:0] Data_OUT,
  output logic                 Valid,
  output logic                 Busy,
  output logic                 FrameError,
  output logic                 Overrun
);

  state_t               state;
  logic [DATA_BITS-1:0] word;
  logic                 last_bit;
  logic                 clear;
  logic                 shift_en;
  logic                 frame_done;
  logic                 frame_bad;
  logic                 overrun_set;

  assign clear       = (state == IDLE) && BitStrobe && !SerialIn;
  assign shift_en    = (state == DATA) && BitStrobe;
  assign frame_done  = (state == STOP) && BitStrobe && SerialIn;
  assign frame_bad   = (state == STOP) && BitStrobe && !SerialIn;
  assign overrun_set = frame_done && Valid && !Ready;
  assign Busy        = (state != IDLE);

  shift_in_register #(
    .DATA_BITS (DATA_BITS),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clock      (clock),
    .reset      (reset),
    .shift_en   (shift_en),
    .clear      (clear),
    .serial_bit (SerialIn),
    .word       (word),
    .last_bit   (last_bit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      Data_OUT   <= '0;
      Valid      <= 1'b0;
      FrameError <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      FrameError <= frame_bad;

      if (BitStrobe) begin
        unique case (state)
          IDLE:    if (!SerialIn) state <= DATA;
          DATA:    if (last_bit)  state <= STOP;
          STOP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      // A completing frame either loads (slot free or being consumed) or is dropped
      if (frame_done && (!Valid || Ready)) begin
        Data_OUT <= word;
        Valid    <= 1'b1;
      end else if (Valid && Ready) begin
        Valid    <= 1'b0;
      end

      if (overrun_set)     Overrun <= 1'b1;
      else if (ClearFlags) Overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_receiver.sv
// Directed bench for shift_receiver: queue-based frame model checked every cycle plus literal expectations.
module tb_shift_receiver;

  localparam int W = 8;
  localparam int LSBF = 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         SerialIn;
  logic         BitStrobe;
  logic         Ready;
  logic         ClearFlags;
  logic [W-1:0] Data_OUT;
  logic         Valid;
  logic         Busy;
  logic         FrameError;
  logic         Overrun;

  int checks = 0;
  int errors = 0;

  shift_receiver #(
    .DATA_BITS (W),
    .LSB_FIRST (LSBF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .SerialIn   (SerialIn),
    .BitStrobe  (BitStrobe),
    .Ready      (Ready),
    .ClearFlags (ClearFlags),
    .Data_OUT   (Data_OUT),
    .Valid      (Valid),
    .Busy       (Busy),
    .FrameError (FrameError),
    .Overrun    (Overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: collects frame bits in a queue, assembles the payload arithmetically.
  logic         m_busy, m_valid, m_fe, m_ovr;
  logic [W-1:0] m_data;
  logic         q[$];

  always @(posedge clock or negedge reset) begin
    logic         done, bad, drop;
    logic [W-1:0] payload;
    if (!reset) begin
      m_busy = 0; m_valid = 0; m_fe = 0; m_ovr = 0; m_data = '0;
      q.delete();
    end else begin
      done = 0; bad = 0; drop = 0;
      if (BitStrobe) begin
        if (!m_busy) begin
          if (!SerialIn) begin m_busy = 1; q.delete(); end
        end else if (q.size() < W) begin
          q.push_back(SerialIn);
        end else begin
          m_busy = 0;
          if (SerialIn) done = 1; else bad = 1;
        end
      end
      m_fe = bad;
      if (done) begin
        payload = '0;
        for (int i = 0; i < W; i++) payload[(LSBF != 0) ? i : (W - 1 - i)] = q[i];
        if (!m_valid || Ready) begin m_data = payload; m_valid = 1; end
        else drop = 1;
      end else if (m_valid && Ready) begin
        m_valid = 0;
      end
      if (drop) m_ovr = 1;
      else if (ClearFlags) m_ovr = 0;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("cyc_data",  16'(Data_OUT),   16'(m_data));
      chk("cyc_valid", 16'(Valid),      16'(m_valid));
      chk("cyc_busy",  16'(Busy),       16'(m_busy));
      chk("cyc_fe",    16'(FrameError), 16'(m_fe));
      chk("cyc_ovr",   16'(Overrun),    16'(m_ovr));
    end
  end

  // Drives start bit, data bits (bit 0 first), stop bit; n limits strobes sent.
  task automatic send_frame(input logic [W-1:0] d, input logic stop, input int gap,
                            input logic rdy_stop, input logic clr_stop, input int n);
    logic [W+1:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin @(posedge clock); #1; end
      SerialIn  = bits[i];
      BitStrobe = 1'b1;
      if (i == W + 1) begin Ready = rdy_stop; ClearFlags = clr_stop; end
      @(posedge clock); #1;
      BitStrobe = 1'b0; SerialIn = 1'b1; Ready = 1'b0; ClearFlags = 1'b0;
    end
  endtask

  task automatic pulse_ready();
    Ready = 1'b1; @(posedge clock); #1; Ready = 1'b0;
  endtask

  task automatic pulse_clear();
    ClearFlags = 1'b1; @(posedge clock); #1; ClearFlags = 1'b0;
  endtask

  initial begin
    reset = 1'b0; SerialIn = 1'b1; BitStrobe = 1'b0; Ready = 1'b0; ClearFlags = 1'b0;
    #1;
    chk("rst_data",  16'(Data_OUT), 16'h0);
    chk("rst_valid", 16'(Valid),    16'h0);
    chk("rst_busy",  16'(Busy),     16'h0);
    chk("rst_ovr",   16'(Overrun),  16'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Good frame A5
    send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0, W + 2);
    chk("a5_data",  16'(Data_OUT),   16'h00A5);
    chk("a5_valid", 16'(Valid),      16'h1);
    chk("a5_fe",    16'(FrameError), 16'h0);
    pulse_ready();
    chk("a5_consumed", 16'(Valid), 16'h0);

    // Bad stop bit
    send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0, W + 2);
    chk("fe_pulse", 16'(FrameError), 16'h1);
    chk("fe_valid", 16'(Valid),      16'h0);
    chk("fe_busy",  16'(Busy),       16'h0);
    @(posedge clock); #1;
    chk("fe_drop",  16'(FrameError), 16'h0);
    chk("fe_data",  16'(Data_OUT),   16'h00A5);

    // Overrun with Ready held low
    send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0, W + 2);
    send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b0, W + 2);
    chk("ovr_data", 16'(Data_OUT), 16'h003C);
    chk("ovr_flag", 16'(Overrun),  16'h1);
    pulse_ready();
    chk("ovr_valid0", 16'(Valid), 16'h0);
    pulse_clear();
    chk("ovr_clear", 16'(Overrun), 16'h0);

    // Overrun set wins over a simultaneous clear
    send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0, W + 2);
    send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b1, W + 2);
    chk("setwin_ovr",  16'(Overrun),  16'h1);
    chk("setwin_data", 16'(Data_OUT), 16'h003C);
    pulse_clear();
    pulse_ready();
    chk("setwin_clr", 16'(Overrun), 16'h0);

    // Ready coincident with the second stop strobe
    send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0, W + 2);
    send_frame(8'hC3, 1'b1, 0, 1'b1, 1'b0, W + 2);
    chk("rdy_data",  16'(Data_OUT), 16'h00C3);
    chk("rdy_valid", 16'(Valid),    16'h1);
    chk("rdy_ovr",   16'(Overrun),  16'h0);

    // Reset after start + 4 data bits, while C3 is still held
    send_frame(8'hFF, 1'b1, 0, 1'b0, 1'b0, 5);
    chk("mid_busy", 16'(Busy), 16'h1);
    #2 reset = 1'b0;
    #1;
    chk("mr_data",  16'(Data_OUT),   16'h0);
    chk("mr_valid", 16'(Valid),      16'h0);
    chk("mr_busy",  16'(Busy),       16'h0);
    chk("mr_fe",    16'(FrameError), 16'h0);
    chk("mr_ovr",   16'(Overrun),    16'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    send_frame(8'h81, 1'b1, 0, 1'b0, 1'b0, W + 2);
    chk("post_rst_data",  16'(Data_OUT), 16'h0081);
    chk("post_rst_valid", 16'(Valid),    16'h1);
    pulse_ready();

    // Strobes separated by 3 idle cycles
    send_frame(8'hA5, 1'b1, 3, 1'b0, 1'b0, W + 2);
    chk("gap_data",  16'(Data_OUT), 16'h00A5);
    chk("gap_valid", 16'(Valid),    16'h1);
    repeat (2) @(posedge clock);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
